// File: rtl/if_fetch.sv
// Instruction fetch stage: PC ownership, single-outstanding imem fetch, registered
// decode handshake with a one-entry skid. Optional JAL pre-decode under JAL_PREDECODE_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_pred_taken,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    state_t      next_state;
    logic        req_q;
    logic [31:0] fetch_pc;

    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred;

    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        skid_pred;

    logic        fire;
    logic        out_free;
    logic        load_out;
    logic        load_skid;
    logic        skid_to_out;
    logic        pc_from_resp;
    logic [31:0] next_pc;
    logic        resp_pred;

    // Handshakes: imem accepts a request when imem_req & imem_gnt in the same cycle;
    // decode takes an instruction when id_valid & id_ready in the same cycle, and the
    // id_* payload is held stable while id_valid & !id_ready.
    assign fire     = req_q & imem_gnt;
    assign out_free = !out_valid || id_ready;

`ifdef JAL_PREDECODE_EN
    logic        resp_is_jal;
    logic [31:0] jal_imm;

    assign resp_is_jal = (imem_rdata[6:0] == 7'b1101111);
    assign jal_imm     = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                          imem_rdata[20], imem_rdata[30:21], 1'b0};
    assign next_pc     = resp_is_jal ? (fetch_pc + jal_imm) : (fetch_pc + 32'd4);
    assign resp_pred   = resp_is_jal;
`else
    assign next_pc     = fetch_pc + 32'd4;
    assign resp_pred   = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        load_out     = 1'b0;
        load_skid    = 1'b0;
        skid_to_out  = 1'b0;
        pc_from_resp = 1'b0;
        if (redirect_valid) begin
            // A fetch already granted must still have its response swallowed.
            case (state)
                S_REQ:   next_state = fire ? S_DRAIN : S_REQ;
                S_WAIT:  next_state = imem_rvalid ? S_REQ : S_DRAIN;
                S_HOLD:  next_state = S_REQ;
                S_DRAIN: next_state = imem_rvalid ? S_REQ : S_DRAIN;
                default: next_state = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (fire) next_state = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_from_resp = 1'b1;
                        if (out_free) begin
                            load_out   = 1'b1;
                            next_state = S_REQ;
                        end else begin
                            load_skid  = 1'b1;
                            next_state = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready && skid_valid) begin
                        skid_to_out = 1'b1;
                        next_state  = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) next_state = S_REQ;
                end
                default: next_state = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            req_q <= 1'b0;
        end else begin
            state <= next_state;
            req_q <= (next_state == S_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            out_valid  <= 1'b0;
            out_instr  <= NOP;
            out_pc     <= 32'h0;
            out_pred   <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= NOP;
            skid_pc    <= 32'h0;
            skid_pred  <= 1'b0;
        end else if (redirect_valid) begin
            // Any transfer decode saw this cycle is void; drop everything held.
            fetch_pc   <= {redirect_pc[31:2], 2'b00};
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (pc_from_resp) fetch_pc <= next_pc;

            if (load_out) begin
                out_valid <= 1'b1;
                out_instr <= imem_rdata;
                out_pc    <= fetch_pc;
                out_pred  <= resp_pred;
            end else if (skid_to_out) begin
                out_valid  <= 1'b1;
                out_instr  <= skid_instr;
                out_pc     <= skid_pc;
                out_pred   <= skid_pred;
                skid_valid <= 1'b0;
            end else if (out_valid && id_ready) begin
                out_valid <= 1'b0;
            end

            if (load_skid) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= fetch_pc;
                skid_pred  <= resp_pred;
            end
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = fetch_pc;
    assign id_valid      = out_valid;
    assign id_instr      = out_instr;
    assign id_pc         = out_pc;
    assign id_pred_taken = out_pred;
    assign dbg_state     = state;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, streaming, skid back-pressure, redirects,
// PC wrap, JAL pre-decode (expectation follows JAL_PREDECODE_EN) and mid-fetch reset.
module tb_if_fetch;

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    if_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant the pending request, then return data one cycle later.
    task automatic fetch(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        logic        exp_pred;
        logic [31:0] exp_next;
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        tick();
        tick();

        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h100);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_pc",    id_pc, 32'h0);
        chk("rst_pred",  {31'h0, id_pred_taken}, 32'h0);
        chk("rst_state", {30'h0, dbg_state}, {30'h0, ST_REQ});

        rst_n = 1'b1;
        tick();
        chk("first_req",  {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h100);

        fetch(32'h0050_0093);
        chk("t1_valid", {31'h0, id_valid}, 32'h1);
        chk("t1_pc",    id_pc, 32'h100);
        chk("t1_instr", id_instr, 32'h0050_0093);
        chk("t1_addr",  imem_addr, 32'h104);
        chk("t1_req",   {31'h0, imem_req}, 32'h1);

        // Back-pressure: 0x104 lands in the skid while 0x100 waits.
        id_ready = 1'b0;
        fetch(32'h0000_1111);
        chk("skid_state", {30'h0, dbg_state}, {30'h0, ST_HOLD});
        for (int i = 0; i < 4; i++) begin
            chk("skid_valid", {31'h0, id_valid}, 32'h1);
            chk("skid_pc",    id_pc, 32'h100);
            chk("skid_instr", id_instr, 32'h0050_0093);
            chk("skid_noreq", {31'h0, imem_req}, 32'h0);
            tick();
        end
        id_ready = 1'b1;
        tick();
        chk("drain_valid", {31'h0, id_valid}, 32'h1);
        chk("drain_pc",    id_pc, 32'h104);
        chk("drain_instr", id_instr, 32'h0000_1111);
        chk("drain_req",   {31'h0, imem_req}, 32'h1);
        chk("drain_addr",  imem_addr, 32'h108);

        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("xfer_fall", {31'h0, id_valid}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_2222;
        tick();
        imem_rvalid = 1'b0;
        chk("third_pc",    id_pc, 32'h108);
        chk("third_instr", id_instr, 32'h0000_2222);
        tick();
        chk("idle_valid", {31'h0, id_valid}, 32'h0);
        chk("idle_addr",  imem_addr, 32'h10C);

        // Redirect while the fetch at 0x10C is in flight.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        chk("rd_drain",  {30'h0, dbg_state}, {30'h0, ST_DRAIN});
        chk("rd_noreq",  {31'h0, imem_req}, 32'h0);
        chk("rd_valid0", {31'h0, id_valid}, 32'h0);
        tick();
        chk("rd_still",  {30'h0, dbg_state}, {30'h0, ST_DRAIN});
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("rd_stale",  {31'h0, id_valid}, 32'h0);
        chk("rd_req",    {31'h0, imem_req}, 32'h1);
        chk("rd_addr",   imem_addr, 32'h200);
        fetch(32'h0000_0013);
        chk("rd_new_pc", id_pc, 32'h200);
        chk("rd_new_v",  {31'h0, id_valid}, 32'h1);

        // Redirect coinciding with the response and id_ready=1.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h0000_3333;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        chk("rv_valid", {31'h0, id_valid}, 32'h0);
        chk("rv_req",   {31'h0, imem_req}, 32'h1);
        chk("rv_addr",  imem_addr, 32'h300);

        // Ungranted request retargets; last redirect wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0404;
        tick();
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_req",  {31'h0, imem_req}, 32'h1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        chk("wrap_pc",   id_pc, 32'hFFFF_FFFC);
        chk("wrap_next", imem_addr, 32'h0);

        // JAL at 0x40 with +8 offset.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        chk("jal_addr", imem_addr, 32'h40);
        fetch(32'h0080_006F);
`ifdef JAL_PREDECODE_EN
        exp_pred = 1'b1;
        exp_next = 32'h48;
`else
        exp_pred = 1'b0;
        exp_next = 32'h44;
`endif
        chk("jal_pc",   id_pc, 32'h40);
        chk("jal_pred", {31'h0, id_pred_taken}, {31'h0, exp_pred});
        chk("jal_next", imem_addr, exp_next);
        fetch(32'h0000_0013);
        chk("after_jal_pc",   id_pc, exp_next);
        chk("after_jal_pred", {31'h0, id_pred_taken}, 32'h0);

        // Reset during WAIT, then a stray response after release.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("mid_wait", {30'h0, dbg_state}, {30'h0, ST_WAIT});
        rst_n = 1'b0;
        #1;
        chk("mr_req",   {31'h0, imem_req}, 32'h0);
        chk("mr_addr",  imem_addr, 32'h100);
        chk("mr_valid", {31'h0, id_valid}, 32'h0);
        chk("mr_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_4444;
        tick();
        imem_rvalid = 1'b0;
        chk("stray_valid", {31'h0, id_valid}, 32'h0);
        chk("stray_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        chk("stray_addr",  imem_addr, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
